// File: rtl/sy_ppl_mdu_sched.sv
// MDU issue scheduler: a one-entry holding register that releases mul/div requests only when
// the divider is free and the request's writeback slot on the shared GPR write port is clear.
module sy_ppl_mdu_sched #(
   parameter int unsigned DWTH        = 64,
   parameter int unsigned PHY_REG_WTH = 6,
   parameter int unsigned ROB_WTH     = 6,
   parameter int unsigned MUL_LAT     = 4,
   parameter int unsigned DIV_LAT     = 21
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   req_vld_i,
   output logic                   req_rdy_o,
   input  logic [2:0]             req_opcode_i,
   input  logic                   req_rs1_sign_i,
   input  logic                   req_rs2_sign_i,
   input  logic [DWTH-1:0]        req_rs1_data_i,
   input  logic [DWTH-1:0]        req_rs2_data_i,
   input  logic [PHY_REG_WTH-1:0] req_rdst_idx_i,
   input  logic                   req_is_32_i,
   input  logic [ROB_WTH-1:0]     req_rob_idx_i,
   output logic                   mdu_en_o,
   output logic [2:0]             mdu_opcode_o,
   output logic                   mdu_rs1_sign_o,
   output logic                   mdu_rs2_sign_o,
   output logic [DWTH-1:0]        mdu_rs1_data_o,
   output logic [DWTH-1:0]        mdu_rs2_data_o,
   output logic [PHY_REG_WTH-1:0] mdu_rdst_idx_o,
   output logic                   mdu_is_32_o,
   output logic [ROB_WTH-1:0]     mdu_rob_idx_o,
   output logic                   div_busy_o,
   output logic [DIV_LAT-1:0]     wb_rsv_o
);

   localparam logic [2:0] OpMul  = 3'd0;
   localparam logic [2:0] OpMulh = 3'd1;
   localparam logic [2:0] OpDiv  = 3'd2;
   localparam logic [2:0] OpRem  = 3'd3;
   localparam int unsigned CntW  = $clog2(DIV_LAT);

   typedef enum logic {DivIdle, DivBusy} div_st_e;

   typedef struct packed {
      logic [2:0]             opcode;
      logic                   rs1_sign;
      logic                   rs2_sign;
      logic [DWTH-1:0]        rs1_data;
      logic [DWTH-1:0]        rs2_data;
      logic [PHY_REG_WTH-1:0] rdst_idx;
      logic                   is_32;
      logic [ROB_WTH-1:0]     rob_idx;
   } hold_t;

   logic              hold_vld_q, hold_vld_d;
   hold_t             hold_q, hold_d;
   // rsv_q[i]: a result writes back i cycles from now. Slot DIV_LAT is never set because the
   // longest op reserves DIV_LAT-1 one edge after issue, so it is not stored.
   logic [DIV_LAT-1:1] rsv_q, rsv_d;
   div_st_e           div_st_q, div_st_d;
   logic [CntW-1:0]   div_cnt_q, div_cnt_d;

   logic is_mul, is_div, can_issue, accept;

   always_comb begin
      is_mul    = (hold_q.opcode == OpMul) || (hold_q.opcode == OpMulh);
      is_div    = (hold_q.opcode == OpDiv) || (hold_q.opcode == OpRem);
      can_issue = hold_vld_q && !flush_i &&
                  ((is_mul && !rsv_q[MUL_LAT]) || (is_div && (div_st_q == DivIdle)));
      req_rdy_o = !flush_i && (!hold_vld_q || can_issue);
      accept    = req_vld_i && req_rdy_o;
   end

   always_comb begin
      hold_vld_d = hold_vld_q;
      hold_d     = hold_q;
      if (flush_i) begin
         hold_vld_d = 1'b0;
      end else if (accept) begin
         hold_vld_d = 1'b1;
         hold_d     = '{opcode:   req_opcode_i,
                        rs1_sign: req_rs1_sign_i,
                        rs2_sign: req_rs2_sign_i,
                        rs1_data: req_rs1_data_i,
                        rs2_data: req_rs2_data_i,
                        rdst_idx: req_rdst_idx_i,
                        is_32:    req_is_32_i,
                        rob_idx:  req_rob_idx_i};
      end else if (can_issue) begin
         hold_vld_d = 1'b0;
      end
   end

   always_comb begin
      rsv_d = {1'b0, rsv_q[DIV_LAT-1:2]};
      if (flush_i) begin
         rsv_d = '0;
      end else if (can_issue && is_mul) begin
         rsv_d[MUL_LAT-1] = 1'b1;
      end else if (can_issue && is_div) begin
         rsv_d[DIV_LAT-1] = 1'b1;
      end
   end

   always_comb begin
      div_st_d  = div_st_q;
      div_cnt_d = div_cnt_q;
      if (flush_i) begin
         div_st_d  = DivIdle;
         div_cnt_d = '0;
      end else begin
         unique case (div_st_q)
            DivIdle: begin
               if (can_issue && is_div) begin
                  div_st_d  = DivBusy;
                  div_cnt_d = CntW'(DIV_LAT - 1);
               end
            end
            DivBusy: begin
               div_cnt_d = div_cnt_q - 1'b1;
               if (div_cnt_q == CntW'(1)) div_st_d = DivIdle;
            end
            default: div_st_d = DivIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_vld_q <= 1'b0;
         rsv_q      <= '0;
         div_st_q   <= DivIdle;
         div_cnt_q  <= '0;
      end else begin
         hold_vld_q <= hold_vld_d;
         rsv_q      <= rsv_d;
         div_st_q   <= div_st_d;
         div_cnt_q  <= div_cnt_d;
      end
   end

   // Payload is qualified by hold_vld_q, so it needs no reset.
   always_ff @(posedge clk_i) begin
      hold_q <= hold_d;
   end

   assign mdu_en_o       = can_issue;
   assign mdu_opcode_o   = hold_q.opcode;
   assign mdu_rs1_sign_o = hold_q.rs1_sign;
   assign mdu_rs2_sign_o = hold_q.rs2_sign;
   assign mdu_rs1_data_o = hold_q.rs1_data;
   assign mdu_rs2_data_o = hold_q.rs2_data;
   assign mdu_rdst_idx_o = hold_q.rdst_idx;
   assign mdu_is_32_o    = hold_q.is_32;
   assign mdu_rob_idx_o  = hold_q.rob_idx;
   assign div_busy_o     = (div_st_q == DivBusy);
   assign wb_rsv_o       = {rsv_q, 1'b0};

endmodule

// File: tb/tb_sy_ppl_mdu_sched.sv
// Scoreboard bench for sy_ppl_mdu_sched: a cycle-level model of writeback slots and divider
// occupancy predicts issue, ready, busy and reservation outputs; issued payloads follow accept order.
module tb_sy_ppl_mdu_sched;

   localparam int DWTH    = 64;
   localparam int PRW     = 6;
   localparam int ROBW    = 6;
   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 21;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            flush_i = 1'b0;
   logic            req_vld_i = 1'b0;
   logic            req_rdy_o;
   logic [2:0]      req_opcode_i = 3'd0;
   logic            req_rs1_sign_i = 1'b0;
   logic            req_rs2_sign_i = 1'b0;
   logic [DWTH-1:0] req_rs1_data_i = '0;
   logic [DWTH-1:0] req_rs2_data_i = '0;
   logic [PRW-1:0]  req_rdst_idx_i = '0;
   logic            req_is_32_i = 1'b0;
   logic [ROBW-1:0] req_rob_idx_i = '0;
   logic            mdu_en_o;
   logic [2:0]      mdu_opcode_o;
   logic            mdu_rs1_sign_o;
   logic            mdu_rs2_sign_o;
   logic [DWTH-1:0] mdu_rs1_data_o;
   logic [DWTH-1:0] mdu_rs2_data_o;
   logic [PRW-1:0]  mdu_rdst_idx_o;
   logic            mdu_is_32_o;
   logic [ROBW-1:0] mdu_rob_idx_o;
   logic            div_busy_o;
   logic [DIV_LAT-1:0] wb_rsv_o;

   sy_ppl_mdu_sched #(
      .DWTH(DWTH), .PHY_REG_WTH(PRW), .ROB_WTH(ROBW), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_opcode_i(req_opcode_i),
      .req_rs1_sign_i(req_rs1_sign_i), .req_rs2_sign_i(req_rs2_sign_i),
      .req_rs1_data_i(req_rs1_data_i), .req_rs2_data_i(req_rs2_data_i),
      .req_rdst_idx_i(req_rdst_idx_i), .req_is_32_i(req_is_32_i), .req_rob_idx_i(req_rob_idx_i),
      .mdu_en_o(mdu_en_o), .mdu_opcode_o(mdu_opcode_o),
      .mdu_rs1_sign_o(mdu_rs1_sign_o), .mdu_rs2_sign_o(mdu_rs2_sign_o),
      .mdu_rs1_data_o(mdu_rs1_data_o), .mdu_rs2_data_o(mdu_rs2_data_o),
      .mdu_rdst_idx_o(mdu_rdst_idx_o), .mdu_is_32_o(mdu_is_32_o), .mdu_rob_idx_o(mdu_rob_idx_o),
      .div_busy_o(div_busy_o), .wb_rsv_o(wb_rsv_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [145:0] payload;
      logic [2:0]   op;
      int           acc;
   } op_t;

   op_t sb[$];
   bit  wb_at[int];   // model: cycles on which a writeback is already booked
   bit  dut_wb[int];  // writeback cycles implied by the DUT's actual issues
   int  last_div = -1000;
   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   int  n_acc = 0;
   int  n_iss = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic bit op_is_div(input logic [2:0] op);
      return (op == 3'd2) || (op == 3'd3);
   endfunction

   always @(negedge clk) begin : monitor
      bit held, exp_en, exp_rdy, exp_busy, hd;
      int lat, dlat;
      logic [DIV_LAT-1:0] exp_rsv;
      logic [145:0] dut_pl;
      if (rst_i) begin
         sb.delete();
         wb_at.delete();
         dut_wb.delete();
         last_div = -1000;
      end else begin
         held   = (sb.size() > 0) && (sb[0].acc < cyc);
         exp_en = 1'b0;
         hd     = 1'b0;
         lat    = MUL_LAT;
         if (held && !flush_i) begin
            hd     = op_is_div(sb[0].op);
            lat    = hd ? DIV_LAT : MUL_LAT;
            exp_en = !wb_at.exists(cyc + lat) && (!hd || (cyc - last_div >= DIV_LAT));
         end
         exp_busy = (cyc - last_div >= 1) && (cyc - last_div <= DIV_LAT - 1);
         exp_rsv  = '0;
         for (int k = 1; k < DIV_LAT; k++) exp_rsv[k] = wb_at.exists(cyc + k);
         check("mdu_en", 160'(mdu_en_o), 160'(exp_en));
         check("div_busy", 160'(div_busy_o), 160'(exp_busy));
         check("wb_rsv", 160'(wb_rsv_o), 160'(exp_rsv));
         if (mdu_en_o) begin
            dlat = op_is_div(mdu_opcode_o) ? DIV_LAT : MUL_LAT;
            check("wb_collision", 160'(dut_wb.exists(cyc + dlat)), 160'(0));
            dut_wb[cyc + dlat] = 1'b1;
            check("issue_has_entry", 160'(held), 160'(1));
            if (held) begin
               dut_pl = {mdu_opcode_o, mdu_rs1_sign_o, mdu_rs2_sign_o, mdu_rs1_data_o,
                         mdu_rs2_data_o, mdu_rdst_idx_o, mdu_is_32_o, mdu_rob_idx_o};
               check("issue_payload", 160'(dut_pl), 160'(sb[0].payload));
            end
         end
         if (exp_en) begin
            wb_at[cyc + lat] = 1'b1;
            if (hd) last_div = cyc;
            void'(sb.pop_front());
            n_iss++;
         end
         exp_rdy = !flush_i && (!held || exp_en);
         check("req_rdy", 160'(req_rdy_o), 160'(exp_rdy));
         if (req_vld_i && exp_rdy) begin
            sb.push_back('{payload: {req_opcode_i, req_rs1_sign_i, req_rs2_sign_i,
                                     req_rs1_data_i, req_rs2_data_i, req_rdst_idx_i,
                                     req_is_32_i, req_rob_idx_i},
                           op: req_opcode_i, acc: cyc});
            n_acc++;
         end
         if (flush_i) begin
            sb.delete();
            wb_at.delete();
            dut_wb.delete();
            last_div = -1000;
         end
      end
   end

   always @(negedge clk) begin
      if (req_vld_i) assert (req_opcode_i <= 3'd3) else $error("illegal opcode presented");
   end

   task automatic step(input bit v, input logic [2:0] op, input bit fl);
      @(posedge clk);
      #1;
      req_vld_i      = v;
      req_opcode_i   = op;
      flush_i        = fl;
      req_rs1_sign_i = 1'($urandom);
      req_rs2_sign_i = 1'($urandom);
      req_rs1_data_i = {$urandom, $urandom};
      req_rs2_data_i = {$urandom, $urandom};
      req_rdst_idx_i = PRW'($urandom);
      req_is_32_i    = 1'($urandom);
      req_rob_idx_i  = ROBW'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0);
   endtask

   initial begin
      int r;
      repeat (3) step(1'b0, 3'd0, 1'b0);
      @(posedge clk);
      #1 rst_i = 1'b0;
      idle(2);
      // single MUL
      step(1'b1, 3'd0, 1'b0);
      idle(8);
      // DIV then MULs every cycle, one lands on the DIV's slot
      step(1'b1, 3'd2, 1'b0);
      for (int i = 0; i < 25; i++) step(1'b1, 3'(i % 2), 1'b0);
      idle(25);
      // two DIVs back to back
      step(1'b1, 3'd2, 1'b0);
      step(1'b1, 3'd3, 1'b0);
      idle(45);
      // flush mid-division with a DIV waiting, then a fresh DIV
      step(1'b1, 3'd2, 1'b0);
      step(1'b1, 3'd3, 1'b0);
      idle(3);
      step(1'b0, 3'd0, 1'b1);
      step(1'b1, 3'd2, 1'b0);
      idle(25);
      // request coincident with flush is dropped
      step(1'b1, 3'd0, 1'b1);
      idle(6);
      // random mix
      for (int i = 0; i < 1500; i++) begin
         r = int'($urandom_range(0, 9));
         step(($urandom_range(0, 9) < 7), (r < 7) ? 3'(r % 2) : 3'(2 + r % 2),
              ($urandom_range(0, 99) == 0));
         if (i == 700) begin
            #1 rst_i = 1'b1;
            idle(2);
            #1 rst_i = 1'b0;
         end
      end
      idle(50);
      check("drained", 160'(sb.size()), 160'(0));
      check("ops_issued", 160'(n_iss > 100), 160'(1));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
